// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store per transaction over a req/gnt/rvalid data port.
// Latency: store 2 cycles (grant in cycle 1), load 3+ cycles; errors reported in cycle 1.
// Backpressure: req_ready only in IDLE; busy stalls the pipeline until done/err.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] wrapper_mem_o,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  // Counter value on the last cycle a grant/rvalid is still honoured.
  localparam logic [7:0] LIM    = 8'(TIMEOUT - 1);

  logic [1:0]  state, state_d;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        accept, illegal, misal, start, tmo;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;

  assign accept = req_valid & req_ready & (is_load | is_store);
  assign busy   = (state != S_IDLE);

  // Decode legality and alignment of the operation presented by execute.
  always_comb begin
    illegal = 1'b0;
    if (is_store) illegal = funct3[2] | (funct3[1:0] == 2'b11);
    else          illegal = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    misal = ((funct3[1:0] == 2'b01) & addr[0]) |
            ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  end

  // Select and extend the returned word using the captured offset and size.
  always_comb begin
    byte_sel = mem_rdata[8*off_q +: 8];
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext = {24'd0, byte_sel};
      3'b101:  ext = {16'd0, half_sel};
      default: ext = mem_rdata;
    endcase
  end

  // Next-state logic; a grant or rvalid on the expiry cycle beats the timeout.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    tmo     = 1'b0;
    case (state)
      S_IDLE: if (accept && !illegal && !misal) begin
        start   = 1'b1;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_gnt)           state_d = mem_we ? S_IDLE : S_WAIT;
        else if (cnt == LIM) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem_rvalid)        state_d = S_IDLE;
        else if (cnt == LIM) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, request fields, status pulses and load result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= 8'd0;
      f3_q          <= 3'd0;
      off_q         <= 2'd0;
      req_ready     <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wdata     <= 32'd0;
      mem_wstrb     <= 4'd0;
      wrapper_mem_o <= 32'd0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= 2'd0;
    end else begin
      state     <= state_d;
      req_ready <= (state_d == S_IDLE);
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      cnt       <= (state_d != state) ? 8'd0 : cnt + 8'd1;
      case (state)
        S_IDLE: begin
          if (accept && illegal) begin
            err      <= 1'b1;
            err_code <= 2'b11;
          end else if (accept && misal) begin
            err      <= 1'b1;
            err_code <= 2'b01;
          end else if (start) begin
            mem_req  <= 1'b1;
            mem_we   <= is_store;
            mem_addr <= {addr[31:2], 2'b00};
            f3_q     <= funct3;
            off_q    <= addr[1:0];
            if (!is_store) begin
              mem_wdata <= 32'd0;
              mem_wstrb <= 4'b0000;
            end else begin
              case (funct3[1:0])
                2'b00: begin
                  mem_wdata <= {4{store_data[7:0]}};
                  mem_wstrb <= 4'b0001 << addr[1:0];
                end
                2'b01: begin
                  mem_wdata <= {2{store_data[15:0]}};
                  mem_wstrb <= 4'b0011 << {addr[1], 1'b0};
                end
                default: begin
                  mem_wdata <= store_data;
                  mem_wstrb <= 4'b1111;
                end
              endcase
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            done    <= mem_we;
          end else if (tmo) begin
            mem_req  <= 1'b0;
            err      <= 1'b1;
            err_code <= 2'b10;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            wrapper_mem_o <= ext;
            done          <= 1'b1;
          end else if (tmo) begin
            err      <= 1'b1;
            err_code <= 2'b10;
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the rv32i core. Accepts one load or store per transaction from execute and drives a single-outstanding request/grant/response data-memory port. Generates byte strobes and replicated store data, and extracts plus sign/zero-extends load data into `wrapper_mem_o`, which feeds the write-back mux. Holds the pipeline via `busy` while a transaction is in flight.

## Interface

**Parameters**
- `TIMEOUT`, default 16: cycles to wait in REQ or WAIT before aborting; legal range 2..255.

**Ports** (name, direction, width, meaning)
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: execute presents a memory operation.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `is_load` in 1: operation is a load.
- `is_store` in 1: operation is a store. `is_load` and `is_store` are never both high.
- `funct3` in 3: access size and sign.
- `addr` in 32: byte address, taken from the ALU result.
- `store_data` in 32: rs2 value.
- `mem_req` out 1: memory request, held until granted.
- `mem_we` out 1: request is a write.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: byte enables; 0000 on loads.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.
- `wrapper_mem_o` out 32: extended load result to write-back.
- `done` out 1: one-cycle pulse when a transaction completes successfully.
- `err` out 1: one-cycle pulse when a transaction aborts.
- `err_code` out 2: valid with `err`. 01 = misaligned, 10 = timeout, 11 = illegal `funct3`.
- `busy` out 1: state is not IDLE; used as the pipeline stall.

## Operation

**Reset.** All outputs are 0 and the state is IDLE. Because reset is asynchronous, `mem_req` drops immediately if reset asserts mid-transaction; no completion is reported.

**Accept.** A transaction is accepted when `req_valid & req_ready & (is_load | is_store)`. At accept, `addr`, `funct3`, `is_store` and `store_data` are captured. The unit ignores `req_valid` while busy.

**Checks at accept.** Illegal `funct3` is checked first, then alignment. When either check fails, the unit makes no memory access, pulses `err` with the code on the next cycle, and stays in IDLE.
- Loads: legal `funct3` is 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: legal `funct3` is 000 SB, 001 SH, 010 SW.
- Misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.

**Store encoding** (registered at accept).
- SB: `mem_wdata = {4{store_data[7:0]}}`, `mem_wstrb = 0001 << addr[1:0]`.
- SH: `mem_wdata = {2{store_data[15:0]}}`, `mem_wstrb = 0011 << {addr[1],1'b0}`.
- SW: `mem_wdata = store_data`, `mem_wstrb = 1111`.

**Load extraction** uses the captured `addr[1:0]`.
- Byte loads select `mem_rdata[8*addr[1:0] +: 8]`.
- Halfword loads select `mem_rdata[16*addr[1] +: 16]`.
- LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged.
- `wrapper_mem_o` holds its value until the next successful load.

**FSM**
- IDLE: on a legal accept, go to REQ.
- REQ: `mem_req` is 1. On `mem_gnt`:
  - store: pulse `done`, go to IDLE.
  - load: go to WAIT.
- WAIT: on `mem_rvalid`, register the extracted data, pulse `done`, go to IDLE.

**Timeout counter**
- Clears on entry to REQ and again on entry to WAIT; increments each cycle spent in REQ or WAIT.
- On reaching `TIMEOUT` with no `mem_gnt` (in REQ) or no `mem_rvalid` (in WAIT): pulse `err` with code 10, drop `mem_req`, go to IDLE.

**Simultaneous events and stray inputs**
- `mem_gnt` or `mem_rvalid` arriving on the expiry cycle wins over the timeout.
- `mem_rvalid` in IDLE or REQ is ignored.
- `mem_gnt` outside REQ is ignored.

## Timing

- All outputs are registered; there is no combinational path from inputs to outputs.
- Accept at cycle 0 means `mem_req`, `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` are valid from cycle 1.
- While `mem_req` is high, the request fields are stable until the grant cycle inclusive. `mem_req` drops the cycle after `mem_gnt`.
- Store, grant in cycle 1: `done` in cycle 2, `req_ready` high in cycle 2. Back-to-back stores run at 2 cycles each.
- Load, grant in cycle 1 and `mem_rvalid` in cycle k≥2: `wrapper_mem_o` is updated and `done` pulses in cycle k+1. The minimum load latency is 3 cycles.
- An error on check failure pulses in cycle 1; `req_ready` stays high throughout.

## Test plan

- **SB:** `addr`=0x1003, `store_data`=0xA5, grant in cycle 1 → `mem_addr`=0x1000, `mem_wstrb`=1000, `mem_wdata`=0xA5A5A5A5, `done` in cycle 2.
- **LB/LBU:** `addr`=0x2002, `mem_rdata`=0x00800000, `mem_rvalid` in cycle 2.
  - LB → `wrapper_mem_o`=0xFFFFFF80 in cycle 3.
  - LBU → 0x00000080.
- **LH misaligned:** `addr`=0x3001 → no `mem_req`, `err` with code 01 in cycle 1. **SW illegal:** store with `funct3`=011 → `err` code 11.
- **Timeout:** `TIMEOUT`=16, `mem_gnt` held low → `err` code 10 after 16 cycles in REQ, `mem_req` low afterwards. Repeat with a grant but no `mem_rvalid` → timeout from WAIT.
- **Back-to-back with delayed grant:** SW then LW, grant 3 cycles late on each, `mem_rdata`=0xDEADBEEF → both `done` pulses occur, `wrapper_mem_o`=0xDEADBEEF, and `busy` stays high exactly during REQ and WAIT.
- **Reset mid-WAIT:** assert `rst_n`=0 asynchronously → `mem_req`, `busy`, `done` and `err` are 0 immediately. A `mem_rvalid` after reset releases is ignored.
